// File: rtl/key_press_display_pkg.sv
// key_press_display_pkg: shared widths and active-low 7-segment patterns (gfedcba).
package key_press_display_pkg;
    localparam int SEG_W = 7;
    localparam int CNT_W = 4;
    localparam int DBC_W = 24;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/key_press_display_debounce.sv
// key_debounce: 2-FF synchroniser, debounce filter and one-cycle press pulse.
module key_debounce
    import key_press_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_pulse
);
    logic             sync_q, key_s_q;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [DBC_W-1:0] cnt_q, cnt_d;
    logic             done;
    always_comb begin
        done     = (key_s_q != stable_q) && (cnt_q == DBC_W'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (key_s_q == stable_q || done) ? '0 : cnt_q + 1'b1;
        stable_d = done ? key_s_q : stable_q;
        pulse_d  = done && key_s_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 1'b0;
            key_s_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= key_in;
            key_s_q  <= sync_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end
    assign key_pulse = pulse_q;
endmodule

// File: rtl/key_press_display.sv
// key_press_display: debounced key-press counter driving one 7-segment digit.
// Define SEG_ACTIVE_HIGH_EN for active-high (common-cathode) seg and dig_sel.
module key_press_display
    import key_press_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COUNT_MAX       = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_in,
    output logic             key_pulse,
    output logic [CNT_W-1:0] count,
    output logic [SEG_W-1:0] seg,
    output logic             dig_sel
);
`ifdef SEG_ACTIVE_HIGH_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif
    logic             pulse;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             dig_sel_q;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_pulse (pulse)
    );
    always_comb begin
        count_d = !pulse ? count_q : (count_q == CNT_W'(COUNT_MAX)) ? '0 : count_q + 1'b1;
        seg_d   = SEG_TABLE[count_q] ^ {SEG_W{POL}};
    end
    // seg follows count with one register stage; polarity is folded in by XOR.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            seg_q     <= SEG_BLANK ^ {SEG_W{POL}};
            dig_sel_q <= !POL;
        end else begin
            count_q   <= count_d;
            seg_q     <= seg_d;
            dig_sel_q <= POL;
        end
    end
    assign key_pulse = pulse;
    assign count     = count_q;
    assign seg       = seg_q;
    assign dig_sel   = dig_sel_q;
endmodule

// File: tb/tb_key_press_display.sv
// tb_key_press_display: scoreboard of expected pulse edges plus table-driven wrap check.
module tb_key_press_display;
    localparam int DBC = 16;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef struct {
        int         exp_count;
        logic [6:0] exp_seg;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b0;
    logic       key_pulse;
    logic [3:0] count;
    logic [6:0] seg;
    logic       dig_sel;
    int         edge_n = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         pend [$];
    int         exp_cnt = 0;
    int         cnt_at = -100;
    bit         live = 1'b0;
    vec_t       vecs [10];
    key_press_display #(.DEBOUNCE_CYCLES(DBC), .COUNT_MAX(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_pulse (key_pulse),
        .count     (count),
        .seg       (seg),
        .dig_sel   (dig_sel)
    );
    always #10 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask
    task automatic mon();
        if (key_pulse) begin
            if (pend.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: key_pulse=1 at edge %0d, expected 0", edge_n);
            end else begin
                chk("pulse_edge", edge_n, pend.pop_front());
            end
            exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
            cnt_at  = edge_n + 1;
        end
        if (edge_n == cnt_at) chk("count_after_pulse", count, exp_cnt);
        if (edge_n == cnt_at + 1) chk("seg_after_count", seg, HEX[exp_cnt]);
        if (live) chk("dig_sel_live", dig_sel, 0);
    endtask
    task automatic step(input logic k);
        key_in = k;
        @(negedge clk);
        mon();
    endtask
    task automatic steps(input logic k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask
    task automatic no_pending(input string name);
        chk(name, pend.size(), 0);
        pend.delete();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        live = 1'b0;
        exp_cnt = 0;
        cnt_at = -100;
        pend.delete();
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            chk("rst_pulse", key_pulse, 0);
            chk("rst_count", count, 0);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_dig_sel", dig_sel, 1);
        end
        rst = 1'b0;
        step(1'b0);
        chk("post_rst_seg", seg, 7'h40);
        chk("post_rst_dig_sel", dig_sel, 0);
        live = 1'b1;
    endtask
    task automatic press(input int hi, input int lo);
        pend.push_back(edge_n + DBC + 2);
        steps(1'b1, hi);
        steps(1'b0, lo);
    endtask
    initial begin
        vecs = '{'{1, 7'h79}, '{2, 7'h24}, '{3, 7'h30}, '{4, 7'h19}, '{5, 7'h12},
                 '{6, 7'h02}, '{7, 7'h78}, '{8, 7'h00}, '{9, 7'h10}, '{0, 7'h40}};
        @(negedge clk);
        do_reset();
        for (int r = 0; r < 3; r++) begin
            steps(1'b1, 2); steps(1'b0, 2); steps(1'b1, 3); steps(1'b0, 1);
            steps(1'b0, 150);
        end
        chk("glitch_count", count, 0);
        chk("glitch_seg", seg, 7'h40);
        press(40, 40);
        no_pending("clean_missed_pulse");
        chk("clean_count", count, 1);
        chk("clean_seg", seg, 7'h79);
        do_reset();
        for (int b = 0; b < 5; b++) begin
            steps(1'b1, $urandom_range(1, 10));
            steps(1'b0, $urandom_range(1, 10));
        end
        pend.push_back(edge_n + DBC + 2);
        steps(1'b1, 100);
        for (int b = 0; b < 5; b++) begin
            steps(1'b0, $urandom_range(1, 10));
            steps(1'b1, $urandom_range(1, 10));
        end
        steps(1'b0, 60);
        no_pending("bounce_missed_pulse");
        chk("bounce_count", count, 1);
        do_reset();
        for (int v = 0; v < 10; v++) begin
            press(25, 25);
            chk($sformatf("wrap_count_%0d", v), count, vecs[v].exp_count);
            chk($sformatf("wrap_seg_%0d", v), seg, vecs[v].exp_seg);
        end
        no_pending("wrap_missed_pulse");
        steps(1'b1, 12);
        rst = 1'b1;
        live = 1'b0;
        exp_cnt = 0;
        cnt_at = -100;
        steps(1'b1, 2);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_seg", seg, 7'h7F);
        rst = 1'b0;
        pend.push_back(edge_n + DBC + 2);
        step(1'b1);
        live = 1'b1;
        steps(1'b1, 30);
        no_pending("mid_rst_missed_pulse");
        chk("mid_rst_final_count", count, 1);
        chk("mid_rst_final_seg", seg, 7'h79);
        steps(1'b0, 40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
